// File: rtl/demux1_2x8_buf.sv
// demux1_2x8_buf: 1-to-2 demultiplexer with an independent 2-entry FIFO
// behind each output. Input words are routed by S into FIFO A or FIFO B.
// The output heads are registered, so there is no combinational path from D to Y.

// Two-slot FIFO with a registered head word and valid/ready output handshake.
module demux1_2x8_buf_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_push,   // already qualified: FIFO is not full
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_rdy,
    output logic [WIDTH-1:0] o_y,
    output logic             o_yv,
    output logic [1:0]       o_cnt
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_rd;
    logic             r_wr;
    logic [1:0]       r_cnt;
    logic [WIDTH-1:0] r_y;

    logic             w_pop;
    logic [1:0]       w_cnt_nxt;
    logic [WIDTH-1:0] w_y_nxt;

    // Next count and next head word, derived from the push/pop pair.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned, which would infer a latch.
        w_pop     = (r_cnt != 2'd0) && i_rdy;
        w_cnt_nxt = r_cnt;
        w_y_nxt   = r_y;

        case ({i_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + 2'd1;
            2'b01:   w_cnt_nxt = r_cnt - 2'd1;
            default: w_cnt_nxt = r_cnt;
        endcase

        if (w_pop) begin
            // Full: the other slot becomes the head. One entry plus push: the
            // incoming word becomes the head. Otherwise the FIFO empties and the
            // head holds its last value.
            if (r_cnt == 2'd2) begin
                w_y_nxt = r_mem[~r_rd];
            end else if (i_push) begin
                w_y_nxt = i_din;
            end
        end else if (i_push && (r_cnt == 2'd0)) begin
            w_y_nxt = i_din;
        end
    end

    // Register file write; contents need no reset because count gates visibility.
    always_ff @(posedge CLK) begin
        // NOTE: the storage array is deliberately not reset. Words in it are
        // never observed while the count says the slot is empty.
        if (!RST && i_push) begin
            // NOTE: sequential state always uses non-blocking assignment so
            // every flop samples the pre-edge values.
            r_mem[r_wr] <= i_din;
        end
    end

    // Pointers, occupancy and the registered head word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rd  <= 1'b0;
            r_wr  <= 1'b0;
            r_cnt <= 2'd0;
            r_y   <= '0;
        end else begin
            // One-bit pointers: inversion is the 1 -> 0 wrap.
            if (i_push) r_wr <= ~r_wr;
            if (w_pop)  r_rd <= ~r_rd;
            r_cnt <= w_cnt_nxt;
            r_y   <= w_y_nxt;
        end
    end

    assign o_y   = r_y;
    assign o_yv  = (r_cnt != 2'd0);
    assign o_cnt = r_cnt;

endmodule

// Top level: route select, input-ready generation and the two output FIFOs.
module demux1_2x8_buf #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    input  logic             S,
    input  logic             DV,
    output logic             DR,
    output logic [WIDTH-1:0] YA,
    output logic [WIDTH-1:0] YB,
    output logic             YAV,
    output logic             YBV,
    input  logic             YAR,
    input  logic             YBR,
    output logic [1:0]       CNTA,
    output logic [1:0]       CNTB
);

    logic [1:0] w_cnt_a;
    logic [1:0] w_cnt_b;
    logic       w_dr;
    logic       w_push_a;
    logic       w_push_b;

    // Ready depends only on the selected FIFO's occupancy; a pop in the same
    // cycle does not free space for a push (no pass-through).
    assign w_dr     = S ? (w_cnt_b != 2'd2) : (w_cnt_a != 2'd2);
    assign w_push_a = DV && w_dr && !S;
    assign w_push_b = DV && w_dr && S;

    demux1_2x8_buf_fifo #(.WIDTH(WIDTH)) u_fifo_a (
        .CLK    (CLK),
        .RST    (RST),
        .i_push (w_push_a),
        .i_din  (D),
        .i_rdy  (YAR),
        .o_y    (YA),
        .o_yv   (YAV),
        .o_cnt  (w_cnt_a)
    );

    demux1_2x8_buf_fifo #(.WIDTH(WIDTH)) u_fifo_b (
        .CLK    (CLK),
        .RST    (RST),
        .i_push (w_push_b),
        .i_din  (D),
        .i_rdy  (YBR),
        .o_y    (YB),
        .o_yv   (YBV),
        .o_cnt  (w_cnt_b)
    );

    assign DR   = w_dr;
    assign CNTA = w_cnt_a;
    assign CNTB = w_cnt_b;

endmodule

// File: tb/tb_demux1_2x8_buf.sv
// Testbench for demux1_2x8_buf: directed sequences plus a random phase.
// The stimulus process pushes accepted words into per-output queues; a
// monitor pops and compares whenever an output transfer happens.
module tb_demux1_2x8_buf;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] D;
    logic       S;
    logic       DV;
    logic       DR;
    logic [7:0] YA;
    logic [7:0] YB;
    logic       YAV;
    logic       YBV;
    logic       YAR;
    logic       YBR;
    logic [1:0] CNTA;
    logic [1:0] CNTB;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q_a [$];
    logic [7:0] q_b [$];
    int         m_cnt_a = 0;
    int         m_cnt_b = 0;

    demux1_2x8_buf #(.WIDTH(8)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .D    (D),
        .S    (S),
        .DV   (DV),
        .DR   (DR),
        .YA   (YA),
        .YB   (YB),
        .YAV  (YAV),
        .YBV  (YBV),
        .YAR  (YAR),
        .YBR  (YBR),
        .CNTA (CNTA),
        .CNTB (CNTB)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock cycle of stimulus. Checks ready/valid/count against the model,
    // records accepted words, then advances to just after the next rising edge.
    task automatic drive(input logic rst, input logic [7:0] d, input logic s,
                         input logic dv, input logic yar, input logic ybr);
        logic exp_dr;
        logic push_a, push_b, pop_a, pop_b;
        RST = rst; D = d; S = s; DV = dv; YAR = yar; YBR = ybr;
        #1;
        exp_dr = s ? (m_cnt_b != 2) : (m_cnt_a != 2);
        check("dr",   DR,   exp_dr);
        check("cnta", CNTA, m_cnt_a);
        check("cntb", CNTB, m_cnt_b);
        check("yav",  YAV,  m_cnt_a != 0);
        check("ybv",  YBV,  m_cnt_b != 0);
        if (rst) begin
            m_cnt_a = 0;
            m_cnt_b = 0;
            q_a.delete();
            q_b.delete();
        end else begin
            push_a = dv && exp_dr && !s;
            push_b = dv && exp_dr && s;
            pop_a  = (m_cnt_a != 0) && yar;
            pop_b  = (m_cnt_b != 0) && ybr;
            if (push_a) q_a.push_back(d);
            if (push_b) q_b.push_back(d);
            m_cnt_a = m_cnt_a + int'(push_a) - int'(pop_a);
            m_cnt_b = m_cnt_b + int'(push_b) - int'(pop_b);
        end
        @(posedge CLK);
        #1;
    endtask

    // Monitor: an output transfer is visible mid-cycle as valid && ready.
    initial begin
        forever begin
            @(negedge CLK);
            if (RST === 1'b0) begin
                if (YAV && YAR) begin
                    if (q_a.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL pop_a: got 0x%0h expected no word", YA);
                    end else begin
                        check("pop_a", YA, q_a.pop_front());
                    end
                end
                if (YBV && YBR) begin
                    if (q_b.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL pop_b: got 0x%0h expected no word", YB);
                    end else begin
                        check("pop_b", YB, q_b.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        RST = 1'b1; D = '0; S = 1'b0; DV = 1'b0; YAR = 1'b0; YBR = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        check("rst_cnta", CNTA, 0);
        check("rst_cntb", CNTB, 0);
        check("rst_ya",   YA,   8'h00);
        check("rst_yb",   YB,   8'h00);
        check("rst_dr",   DR,   1'b1);

        // Single word into A, visible one cycle later.
        drive(0, 8'h5A, 0, 1, 0, 0);
        check("t27_ya", YA, 8'h5A);
        check("t27_yav", YAV, 1'b1);
        check("t27_cnta", CNTA, 2'd1);
        check("t27_ybv", YBV, 1'b0);
        drive(0, 8'h00, 0, 0, 1, 0);

        // Fill A, third word rejected, B still accepts.
        drive(0, 8'h11, 0, 1, 0, 0);
        drive(0, 8'h22, 0, 1, 0, 0);
        check("t28_cnta", CNTA, 2'd2);
        check("t28_ya", YA, 8'h11);
        drive(0, 8'h33, 0, 1, 0, 0);
        check("t28_cnta_hold", CNTA, 2'd2);
        drive(0, 8'h44, 1, 1, 0, 0);
        check("t28_yb", YB, 8'h44);
        check("t28_ybv", YBV, 1'b1);

        // Full A: pop and rejected push in the same cycle.
        drive(0, 8'h33, 0, 1, 1, 0);
        check("t29_cnta", CNTA, 2'd1);
        check("t29_ya", YA, 8'h22);

        // Drain A: head holds its last value once empty.
        drive(0, 8'h00, 0, 0, 1, 0);
        check("t21_yav", YAV, 1'b0);
        check("t21_ya_hold", YA, 8'h22);
        drive(0, 8'h00, 0, 0, 1, 0);
        check("t21_cnta", CNTA, 2'd0);

        // Simultaneous push and pop on a one-entry FIFO.
        drive(0, 8'hAA, 0, 1, 0, 0);
        drive(0, 8'hBB, 0, 1, 1, 0);
        check("t30_cnta", CNTA, 2'd1);
        check("t30_ya", YA, 8'hBB);

        // Reset with words buffered and DV high.
        drive(0, 8'hCC, 0, 1, 0, 0);
        check("t31_pre_cnta", CNTA, 2'd2);
        check("t31_pre_cntb", CNTB, 2'd1);
        drive(1, 8'hDD, 0, 1, 0, 0);
        check("t31_cnta", CNTA, 2'd0);
        check("t31_cntb", CNTB, 2'd0);
        check("t31_yav", YAV, 1'b0);
        check("t31_ybv", YBV, 1'b0);
        check("t31_ya", YA, 8'h00);
        check("t31_yb", YB, 8'h00);
        drive(0, 8'h00, 0, 0, 0, 0);
        check("t31_no_capture", CNTA, 2'd0);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 1000; i++) begin
            drive(0, 8'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end
        repeat (3) drive(0, 8'h00, 0, 0, 1, 1);
        check("drain_a", q_a.size(), 0);
        check("drain_b", q_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
